mem_arbiter: RTL and testbench

- Single-owner controller for the shared slowmem port, sitting between the threaded processor and slowmem.
- Accepts four requesters (instruction fetch and data load/store for each of the two PIDs) and grants one transaction at a time.
- Drives the slowmem strobe/rnotw/addr/wdata handshake and returns the read data with a one-cycle ack to the winning requester.
- Guarantees fair PID interleaving and bounded wait for fetch.

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single owner of the shared slowmem port. Arbitrates four
// requesters (fetch/data for PID0/PID1), runs one strobe/mfc transaction at a
// time and returns a one-cycle ack (plus err on a read timeout).
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no transaction; arbitrate and latch the winner on any req
// S_ISSUE | strobe high for one cycle toward slowmem
// S_WAIT  | read in flight; wait for mfc or count toward timeout
// S_ACK   | one-cycle ack to the granted requester, then back to idle
module mem_arbiter #(
  parameter int TIMEOUT      = 16,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  rnotw_in,
  input  logic [63:0] addr_in,
  input  logic [63:0] wdata_in,
  output logic [3:0]  ack,
  output logic [15:0] rdata_out,
  output logic        err,
  output logic        busy,
  output logic        mem_strobe,
  output logic        mem_rnotw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_mfc,
  input  logic [15:0] mem_rdata
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             lp_fetch_q, lp_fetch_d;
  logic             lp_data_q, lp_data_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             strobe_q, strobe_d;
  logic             rnotw_q, rnotw_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [3:0]       ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic       starve, pick_data, cls_lp, win_pid;
  logic [1:0] cls, win_idx;
  logic [3:0] gnt_onehot;

  // Data class normally wins; a fetch waiting behind a full data run takes
  // the slot. Inside a class the PID that did not win last time goes first.
  assign starve     = (run_q == RUN_MAX) && (|req[1:0]);
  assign pick_data  = (|req[3:2]) && !starve;
  assign cls        = pick_data ? req[3:2] : req[1:0];
  assign cls_lp     = pick_data ? lp_data_q : lp_fetch_q;
  assign win_pid    = (cls == 2'b11) ? ~cls_lp : cls[1];
  assign win_idx    = {pick_data, win_pid};
  assign gnt_onehot = 4'b0001 << gnt_q;

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    lp_fetch_d = lp_fetch_q;
    lp_data_d  = lp_data_q;
    run_d      = run_q;
    tmo_d      = tmo_q;
    strobe_d   = strobe_q;
    rnotw_d    = rnotw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ack_d      = 4'b0000;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d    = win_idx;
          // fetches are always reads, whatever the requester drives
          rnotw_d  = win_idx[1] ? rnotw_in[win_idx] : 1'b1;
          addr_d   = addr_in[{win_idx, 4'b0000} +: 16];
          wdata_d  = wdata_in[{win_idx, 4'b0000} +: 16];
          strobe_d = 1'b1;
          state_d  = S_ISSUE;
          if (pick_data) begin
            lp_data_d = win_pid;
            if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
          end else begin
            lp_fetch_d = win_pid;
            run_d      = '0;
          end
        end
      end
      S_ISSUE: begin
        strobe_d = 1'b0;
        if (rnotw_q) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          ack_d   = gnt_onehot;
          state_d = S_ACK;
        end
      end
      S_WAIT: begin
        if (mem_mfc) begin
          rdata_d = mem_rdata;
          ack_d   = gnt_onehot;
          state_d = S_ACK;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d = 16'h0000;
          err_d   = 1'b1;
          ack_d   = gnt_onehot;
          state_d = S_ACK;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      lp_fetch_q <= 1'b1;
      lp_data_q  <= 1'b1;
      run_q      <= '0;
      tmo_q      <= '0;
      strobe_q   <= 1'b0;
      rnotw_q    <= 1'b1;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      rdata_q    <= 16'h0000;
      ack_q      <= 4'b0000;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      lp_fetch_q <= lp_fetch_d;
      lp_data_q  <= lp_data_d;
      run_q      <= run_d;
      tmo_q      <= tmo_d;
      strobe_q   <= strobe_d;
      rnotw_q    <= rnotw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign rdata_out  = rdata_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign mem_strobe = strobe_q;
  assign mem_rnotw  = rnotw_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural slowmem plus a transaction-level
// reference model of arbitration order, memory contents and latency.
module tb_mem_arbiter;
  localparam int TIMEOUT      = 16;
  localparam int MAX_DATA_RUN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  rnotw_in = 4'b1111;
  logic [63:0] addr_in = '0;
  logic [63:0] wdata_in = '0;
  logic [3:0]  ack;
  logic [15:0] rdata_out;
  logic        err, busy, mem_strobe, mem_rnotw;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_mfc;
  logic [15:0] mem_rdata = 16'h0000;
  logic        sm_mfc = 1'b0;
  logic        stray_mfc = 1'b0;

  assign mem_mfc = sm_mfc | stray_mfc;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .MAX_DATA_RUN(MAX_DATA_RUN)) dut (
    .clk(clk), .reset(reset), .req(req), .rnotw_in(rnotw_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .ack(ack), .rdata_out(rdata_out),
    .err(err), .busy(busy), .mem_strobe(mem_strobe), .mem_rnotw(mem_rnotw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mfc(mem_mfc),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return 16'h1234 + a * 16'h0101;
  endfunction

  // Slowmem: sees strobe on a falling edge, answers a read sm_dly cycles later
  // with a one-cycle mfc; sm_sup suppresses the answer entirely.
  logic [15:0] sm_mem [int];
  int          sm_cnt = 0;
  int          sm_dly = 4;
  bit          sm_sup = 1'b0;
  logic [15:0] sm_a = 16'h0000;

  always @(negedge clk) begin
    sm_mfc    = 1'b0;
    mem_rdata = 16'($urandom);
    if (!reset) begin
      sm_cnt = 0;
    end else begin
      if (sm_cnt > 0) begin
        sm_cnt--;
        if (sm_cnt == 0) begin
          sm_mfc    = 1'b1;
          mem_rdata = sm_mem.exists(int'(sm_a)) ? sm_mem[int'(sm_a)] : init_val(sm_a);
        end
      end
      if (mem_strobe) begin
        sm_a = mem_addr;
        if (!mem_rnotw) sm_mem[int'(mem_addr)] = mem_wdata;
        else if (!sm_sup) sm_cnt = sm_dly;
      end
    end
  end

  // Reference model: class/PID fairness rules and an ideal memory.
  int          lp_f, lp_d, run;
  logic [15:0] ref_mem [int];
  bit          at_ack = 1'b0;

  task automatic model_reset();
    lp_f = 1;
    lp_d = 1;
    run  = 0;
  endtask

  task automatic model_grant(input logic [3:0] r, output int w);
    bit         use_data;
    logic [1:0] cls;
    int         lp, pid;
    use_data = (r[3:2] != 2'b00) && !(run == MAX_DATA_RUN && r[1:0] != 2'b00);
    cls      = use_data ? r[3:2] : r[1:0];
    lp       = use_data ? lp_d : lp_f;
    if (cls == 2'b11) pid = 1 - lp;
    else              pid = cls[1] ? 1 : 0;
    if (use_data) begin
      lp_d = pid;
      run  = (run < MAX_DATA_RUN) ? run + 1 : MAX_DATA_RUN;
      w    = 2 + pid;
    end else begin
      lp_f = pid;
      run  = 0;
      w    = pid;
    end
  endtask

  // Called on a falling edge with the DUT idle or in its ack cycle.
  task automatic run_txn(input string tag, input logic [3:0] r, output logic [3:0] ack_s);
    int          w, s, a, nstb, exp_lat;
    bit          rd, tmo;
    logic [15:0] ea, ew, exp_rd, rd_s, addr_s, wdata_s;
    logic        err_s, rnotw_s, err0;
    logic [3:0]  ack0;
    req = r;
    model_grant(r, w);
    rd  = (w < 2) ? 1'b1 : rnotw_in[w];
    ea  = addr_in[16*w +: 16];
    ew  = wdata_in[16*w +: 16];
    tmo = rd && sm_sup;
    if (!rd) ref_mem[int'(ea)] = ew;
    exp_rd  = tmo ? 16'h0000 : (ref_mem.exists(int'(ea)) ? ref_mem[int'(ea)] : init_val(ea));
    exp_lat = !rd ? 1 : (tmo ? TIMEOUT + 1 : sm_dly + 1);
    s = -1; a = -1; nstb = 0;
    ack_s = 4'b0000; rd_s = 16'h0000; err_s = 1'b0; ack0 = 4'b0000; err0 = 1'b0;
    addr_s = 16'h0000; wdata_s = 16'h0000; rnotw_s = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0) begin
        ack0 = ack;
        err0 = err;
      end
      if (mem_strobe) begin
        if (s < 0) begin
          s = i; addr_s = mem_addr; wdata_s = mem_wdata; rnotw_s = mem_rnotw;
        end
        nstb++;
      end
      if (ack != 4'b0000) begin
        a = i; ack_s = ack; rd_s = rdata_out; err_s = err;
        break;
      end
    end
    check_eq({tag, ".ack_clear"}, {ack0, err0}, 5'b00000);
    check_eq({tag, ".start"}, s, at_ack ? 1 : 0);
    check_eq({tag, ".strobe_len"}, nstb, 1);
    check_eq({tag, ".addr"}, addr_s, ea);
    check_eq({tag, ".rnotw"}, rnotw_s, rd);
    if (!rd) check_eq({tag, ".wdata"}, wdata_s, ew);
    check_eq({tag, ".ack"}, ack_s, 1 << w);
    check_eq({tag, ".latency"}, a - s, exp_lat);
    check_eq({tag, ".err"}, err_s, tmo);
    if (rd) check_eq({tag, ".rdata"}, rd_s, exp_rd);
    at_ack = 1'b1;
  endtask

  task automatic idle(input int n);
    req = 4'b0000;
    repeat (n) @(negedge clk);
    at_ack = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; req = 4'b0000; sm_sup = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    at_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".ack"}, ack, 4'b0000);
    check_eq({tag, ".err_busy_stb"}, {err, busy, mem_strobe}, 3'b000);
    check_eq({tag, ".rnotw"}, mem_rnotw, 1'b1);
    check_eq({tag, ".addr_wdata"}, {mem_addr, mem_wdata}, 32'h0);
    check_eq({tag, ".rdata"}, rdata_out, 16'h0000);
  endtask

  int exp_rr [4]     = '{0, 1, 0, 1};
  int exp_starve [7] = '{2, 3, 2, 3, 0, 2, 3};

  initial begin
    logic [3:0] a_s;
    int         n_ack, n_busy;
    model_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // single fetch from address 0
    rnotw_in = 4'b1111; addr_in = '0; sm_dly = 4;
    run_txn("fetch", 4'b0001, a_s);
    idle(1);

    // write then read back on data PID0
    rnotw_in = 4'b1011; addr_in[47:32] = 16'h0040; wdata_in[47:32] = 16'hBEEF;
    run_txn("write", 4'b0100, a_s);
    idle(1);
    rnotw_in = 4'b1111;
    run_txn("readback", 4'b0100, a_s);
    idle(1);

    // fetch round-robin, winner drops req for one cycle
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      run_txn("rr", 4'b0011, a_s);
      check_eq("rr.order", a_s, 1 << exp_rr[k]);
      req = 4'b0011 & ~a_s;
      @(negedge clk);
      at_ack = 1'b0;
    end
    idle(1);

    // data stream with a waiting fetch
    apply_reset();
    rnotw_in = 4'b1111; sm_dly = 1;
    for (int k = 0; k < 7; k++) begin
      run_txn("starve", 4'b1101, a_s);
      check_eq("starve.order", a_s, 1 << exp_starve[k]);
    end
    idle(1);

    // read timeout on fetch PID1
    sm_sup = 1'b1;
    run_txn("timeout", 4'b0010, a_s);
    sm_sup = 1'b0;
    idle(1);

    // reset in the middle of a read
    sm_sup = 1'b1; addr_in[15:0] = 16'h0000;
    req = 4'b0001;
    repeat (4) @(negedge clk);
    check_eq("midrst.busy_before", busy, 1'b1);
    reset = 1'b0;
    #1 check_reset_outputs("midrst");
    stray_mfc = 1'b1;
    @(negedge clk);
    req = 4'b0000; stray_mfc = 1'b0; sm_sup = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    stray_mfc = 1'b1;
    @(negedge clk);
    stray_mfc = 1'b0;
    n_ack = 0; n_busy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack != 4'b0000) n_ack++;
      if (busy) n_busy++;
    end
    check_eq("midrst.no_ack", n_ack, 0);
    check_eq("midrst.no_busy", n_busy, 0);
    at_ack = 1'b0; sm_dly = 4;
    run_txn("post_rst", 4'b0001, a_s);
    idle(1);

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      rnotw_in = 4'($urandom);
      for (int j = 0; j < 4; j++) begin
        addr_in[16*j +: 16]  = 16'($urandom_range(0, 15));
        wdata_in[16*j +: 16] = 16'($urandom);
      end
      sm_dly = $urandom_range(1, 8);
      sm_sup = ($urandom_range(0, 7) == 0);
      run_txn("rand", 4'($urandom_range(1, 15)), a_s);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    sm_sup = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
